alu_operand_stage: RTL and testbench

- Upstream neighbour of the ALU in the single-cycle datapath.
- Holds the architectural register file: 32 x 32-bit, two combinational read ports, one clocked write port, register 0 hardwired to zero.
- Forms the two ALU operands `a` and `b` from register data, the shift amount, or the 16-bit immediate.
- Also provides a debug read port for the testbench.

---
 rtl/alu_operand_stage.sv | 91 +++++++++
 tb/tb_alu_operand_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Architectural register file plus ALU operand formation for a
//                single-cycle datapath.
//                - 2**AW x DW registers, register 0 hardwired to zero
//                - two combinational read ports (qa, qb) and a debug read port
//                - one write port, committed on the rising edge of clk
//                - operand a: register A or zero-extended shift amount
//                - operand b: register B or sign/zero-extended 16-bit immediate
//
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous reset, active-high (clears registers)
//                rna/rnb  - read addresses for qa / qb
//                we/wn/d  - write enable, write address, write data
//                shift/sa - select shift amount for operand a / amount field
//                aluimm   - select immediate for operand b
//                sext/imm - sign-extend select / immediate field
//                qa/qb    - raw register reads
//                a/b      - ALU operands
//                dbg_addr/dbg_data - debug read port
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    input  logic          we,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] d,
    input  logic          shift,
    input  logic [4:0]    sa,
    input  logic          aluimm,
    input  logic          sext,
    input  logic [15:0]   imm,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int NREG = 2 ** AW;

    // Flattened view of the register file; entry 0 is a constant zero so the
    // read ports need no separate address-zero check.
    logic [DW-1:0] w_rf [NREG];

    assign w_rf[0] = '0;

    // One storage register per architectural register 1..NREG-1. Reset wins
    // over a simultaneous write.
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
        logic [DW-1:0] r_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (we && (wn == AW'(gi))) begin
                r_q <= d;
            end
        end

        assign w_rf[gi] = r_q;
    end

    // Reads deliberately have no write bypass: d is produced from a/b in the
    // same cycle, so forwarding d here would close a combinational loop.
    assign qa       = w_rf[rna];
    assign qb       = w_rf[rnb];
    assign dbg_data = w_rf[dbg_addr];

    // Operand formation.
    logic [DW-1:0] w_sa_ext;
    logic [DW-1:0] w_imm_ext;

    assign w_sa_ext  = {{(DW-5){1'b0}}, sa};
    assign w_imm_ext = sext ? {{(DW-16){imm[15]}}, imm}
                            : {{(DW-16){1'b0}}, imm};

    assign a = shift  ? w_sa_ext  : qa;
    assign b = aluimm ? w_imm_ext : qb;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage. Expected values
//                are queued when stimulus is applied and popped when the
//                outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, we, shift, aluimm, sext;
    logic [AW-1:0] rna, rnb, wn, dbg_addr;
    logic [DW-1:0] d;
    logic [4:0]    sa;
    logic [15:0]   imm;
    wire  [DW-1:0] qa, qb, a, b, dbg_data;

    always #5 clk = ~clk;

    alu_operand_stage #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rna      (rna),
        .rnb      (rnb),
        .we       (we),
        .wn       (wn),
        .d        (d),
        .shift    (shift),
        .sa       (sa),
        .aluimm   (aluimm),
        .sext     (sext),
        .imm      (imm),
        .qa       (qa),
        .qb       (qb),
        .a        (a),
        .b        (b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Reference register file.
    logic [DW-1:0] model [NREG];

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] ad);
        return (ad == '0) ? '0 : model[ad];
    endfunction

    function automatic logic [DW-1:0] exp_a();
        return shift ? {27'b0, sa} : rd(rna);
    endfunction

    function automatic logic [DW-1:0] exp_b();
        if (!aluimm) return rd(rnb);
        return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
    endfunction

    task automatic push(input string t, input logic [DW-1:0] e);
        sb.push_back('{t, e});
    endtask

    task automatic pop_cmp(input logic [DW-1:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %h required none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_bad++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Expectations for all five outputs from the reference model.
    task automatic push_all(input string t);
        push({t, "_qa"},  rd(rna));
        push({t, "_qb"},  rd(rnb));
        push({t, "_dbg"}, rd(dbg_addr));
        push({t, "_a"},   exp_a());
        push({t, "_b"},   exp_b());
    endtask

    task automatic cmp_all();
        #1;
        pop_cmp(qa);
        pop_cmp(qb);
        pop_cmp(dbg_data);
        pop_cmp(a);
        pop_cmp(b);
    endtask

    // Advance one rising edge, mirror its effect in the model, and return to
    // the falling edge where stimulus is changed.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 1; i < NREG; i++) model[i] = '0;
        end else if (we && wn != '0) begin
            model[wn] = d;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; we = 0; wn = '0; d = '0;
        rna = '0; rnb = '0; dbg_addr = '0;
        shift = 0; sa = '0; aluimm = 0; sext = 0; imm = '0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) model[i] = '0;
        idle();
        @(negedge clk);

        // Reset state
        rst = 1; tick(); rst = 0;
        rna = 5'd5; rnb = 5'd31; dbg_addr = 5'd17;
        push_all("reset"); cmp_all();

        // Reset clears a written register
        we = 1; wn = 5'd5; d = 32'hDEADBEEF; tick(); we = 0;
        rna = 5'd5;
        push("wr5", 32'hDEADBEEF); #1; pop_cmp(qa);
        rst = 1; tick(); rst = 0;
        push("rst_clr5", 32'h0); #1; pop_cmp(qa);

        // Register 0 is immutable
        we = 1; wn = 5'd0; d = 32'hFFFFFFFF; tick(); we = 0;
        rna = 5'd0; dbg_addr = 5'd0;
        push("r0_qa", 32'h0); push("r0_a", 32'h0); push("r0_dbg", 32'h0);
        #1; pop_cmp(qa); pop_cmp(a); pop_cmp(dbg_data);

        // Write/read timing: old value before the edge, new value after
        we = 1; wn = 5'd7; d = 32'h12345678; rna = 5'd7; rnb = 5'd7;
        push("pre_qa", 32'h0); push("pre_qb", 32'h0);
        #1; pop_cmp(qa); pop_cmp(qb);
        tick(); we = 0;
        push("post_qa", 32'h12345678); push("post_qb", 32'h12345678);
        #1; pop_cmp(qa); pop_cmp(qb);

        // Reset beats a simultaneous write
        rst = 1; we = 1; wn = 5'd3; d = 32'hAAAA5555; tick();
        rst = 0; we = 0; rna = 5'd3;
        push("rst_vs_wr", 32'h0); #1; pop_cmp(qa);

        // Operand muxes
        shift = 1; sa = 5'h1F;
        push("shift_a", 32'h0000001F); #1; pop_cmp(a);
        shift = 0;
        aluimm = 1; imm = 16'h8001; sext = 1;
        push("imm_sext", 32'hFFFF8001); #1; pop_cmp(b);
        sext = 0;
        push("imm_zext", 32'h00008001); #1; pop_cmp(b);
        aluimm = 0;
        we = 1; wn = 5'd9; d = 32'h0000CAFE; tick(); we = 0;
        rnb = 5'd9; sext = 1;
        push("b_reg9", 32'h0000CAFE); #1; pop_cmp(b);

        // Sweep: every register 1..31 through all three read ports
        for (int i = 1; i < NREG; i++) begin
            we = 1; wn = AW'(i); d = i * 32'h01010101; tick();
        end
        we = 0;
        for (int i = 1; i < NREG; i++) begin
            rna = AW'(i); rnb = AW'(i); dbg_addr = AW'(i);
            push("sweep_qa",  i * 32'h01010101);
            push("sweep_qb",  i * 32'h01010101);
            push("sweep_dbg", i * 32'h01010101);
            #1; pop_cmp(qa); pop_cmp(qb); pop_cmp(dbg_data);
            @(negedge clk);
        end

        // Random traffic against the reference model
        for (int n = 0; n < 1000; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            we       = $urandom_range(0, 1);
            wn       = AW'($urandom);
            d        = $urandom;
            rna      = AW'($urandom);
            rnb      = ($urandom_range(0, 3) == 0) ? wn : AW'($urandom);
            dbg_addr = AW'($urandom);
            shift    = $urandom_range(0, 1);
            sa       = 5'($urandom);
            aluimm   = $urandom_range(0, 1);
            sext     = $urandom_range(0, 1);
            imm      = 16'($urandom);
            push_all("rand");
            cmp_all();
            tick();
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_leftover: observed %0d required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
